// File: rtl/skew_input_buffer_if.sv
// ---------------------------------------------------------------------------
// skew_input_buffer_if
// Bundles the access and stream signals of skew_input_buffer so the loader
// side and the buffer share one connection.
//
// Signals:
//   retn     retention enable; low freezes the stream and blocks accesses
//   cen      chip enable, active-low
//   wen      write enable, active-low
//   a        random-access row address
//   d        write row; lane i = d[i*DW +: DW]
//   start    one-cycle stream request
//   base     first row of the stream
//   len      number of rows to stream, 0..DEPTH
//   q        read or stream data; lane i = q[i*DW +: DW]
//   q_valid  q carries data this cycle
//   busy     stream in progress
//   done     one-cycle pulse when a stream completes
//
// Modports: master drives requests (loader / bench), slave is the buffer.
// ---------------------------------------------------------------------------
interface skew_input_buffer_if #(
    parameter int DW    = 8,
    parameter int LANES = 16,
    parameter int AW    = 5
);
    logic                  retn;
    logic                  cen;
    logic                  wen;
    logic [AW-1:0]         a;
    logic [LANES*DW-1:0]   d;
    logic                  start;
    logic [AW-1:0]         base;
    logic [AW:0]           len;
    logic [LANES*DW-1:0]   q;
    logic                  q_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output retn, cen, wen, a, d, start, base, len,
        input  q, q_valid, busy, done
    );

    modport slave (
        input  retn, cen, wen, a, d, start, base, len,
        output q, q_valid, busy, done
    );
endinterface

// File: rtl/skew_input_buffer.sv
// ---------------------------------------------------------------------------
// skew_input_buffer
// Row-organised activation buffer feeding the west edge of the systolic
// array. Offers random-access row reads/writes and a streaming mode that
// reads LEN consecutive rows (wrapping past DEPTH-1) starting at BASE.
//
// Build option: define INBUF_SKEW_EN to build per-lane delay lines so lane i
// of a streamed row appears i cycles after lane 0. Without it, streamed rows
// come out aligned and the drain phase is a single cycle.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset; clears memory, outputs and FSM
//   bus     skew_input_buffer_if.slave (access, stream control, outputs)
// ---------------------------------------------------------------------------
module skew_input_buffer #(
    parameter int DW    = 8,
    parameter int LANES = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    skew_input_buffer_if.slave  bus
);

    localparam int RW = LANES * DW;
    localparam int CW = $clog2(LANES) + 1;

`ifdef INBUF_SKEW_EN
    // Last drain count: LANES-1 cycles flush zeros through the delay lines,
    // the extra exit edge clears Q_VALID and raises DONE.
    localparam int DRAIN_LAST = LANES - 1;
`else
    localparam int DRAIN_LAST = 0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    logic [RW-1:0]  mem_q [DEPTH];
    state_t         state_q;
    logic [AW-1:0]  ptr_q;
    logic [AW:0]    remain_q;
    logic [CW-1:0]  drainCnt_q;
    logic [RW-1:0]  qOut_q;
    logic           qValid_q;
    logic           busy_q;
    logic           done_q;

    logic [RW-1:0]  feedRow_d;
    logic           feedValid_d;
    logic [RW-1:0]  streamQ_d;
    logic           streamValid_d;

`ifdef INBUF_SKEW_EN
    // dly_q[i][j] is stage j of lane i; only stages j < i are ever tapped.
    logic [DW-1:0]  dly_q      [LANES][LANES];
    logic           dlyValid_q [LANES][LANES];
`endif

    // Next stream output: the row read this cycle (zeros outside STREAM)
    // goes straight to lane 0, other lanes come from their delay-line taps.
    always_comb begin
        feedValid_d = (state_q == STREAM);
        feedRow_d   = feedValid_d ? mem_q[ptr_q] : '0;
`ifdef INBUF_SKEW_EN
        streamQ_d           = '0;
        streamQ_d[0 +: DW]  = feedRow_d[0 +: DW];
        streamValid_d       = feedValid_d;
        for (int i = 1; i < LANES; i++) begin
            streamQ_d[i*DW +: DW] = dly_q[i][i-1];
            streamValid_d         = streamValid_d | dlyValid_q[i][i-1];
        end
`else
        streamQ_d     = feedRow_d;
        streamValid_d = feedValid_d;
`endif
    end

    // Main FSM: random access in IDLE, row streaming in STREAM, flush in
    // DRAIN. RETN low freezes all stream state and only blanks Q_VALID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            remain_q   <= '0;
            drainCnt_q <= '0;
            qOut_q     <= '0;
            qValid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
`ifdef INBUF_SKEW_EN
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < LANES; j++) begin
                    dly_q[i][j]      <= '0;
                    dlyValid_q[i][j] <= 1'b0;
                end
            end
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.retn) begin
                        qOut_q   <= '0;
                        qValid_q <= 1'b0;
                    end else if (bus.start) begin
                        ptr_q      <= bus.base;
                        remain_q   <= bus.len;
                        drainCnt_q <= '0;
                        busy_q     <= 1'b1;
                        qOut_q     <= '0;
                        qValid_q   <= 1'b0;
                        state_q    <= (bus.len == '0) ? DRAIN : STREAM;
                    end else if (!bus.cen && !bus.wen) begin
                        mem_q[bus.a] <= bus.d;
                        qOut_q       <= '0;
                        qValid_q     <= 1'b0;
                    end else if (!bus.cen) begin
                        qOut_q   <= mem_q[bus.a];
                        qValid_q <= 1'b1;
                    end else begin
                        qOut_q   <= '0;
                        qValid_q <= 1'b0;
                    end
                end

                STREAM, DRAIN: begin
                    if (!bus.retn) begin
                        qValid_q <= 1'b0;
                    end else begin
                        qOut_q   <= streamQ_d;
                        qValid_q <= streamValid_d;
`ifdef INBUF_SKEW_EN
                        for (int i = 0; i < LANES; i++) begin
                            dly_q[i][0]      <= feedRow_d[i*DW +: DW];
                            dlyValid_q[i][0] <= feedValid_d;
                            for (int j = 1; j < LANES; j++) begin
                                dly_q[i][j]      <= dly_q[i][j-1];
                                dlyValid_q[i][j] <= dlyValid_q[i][j-1];
                            end
                        end
`endif
                        if (state_q == STREAM) begin
                            // Running pointer wraps so BASE+k never leaves the array.
                            ptr_q    <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
                            remain_q <= remain_q - (AW+1)'(1);
                            if (remain_q == (AW+1)'(1)) begin
                                state_q    <= DRAIN;
                                drainCnt_q <= CW'(DRAIN_LAST);
                            end
                        end else if (drainCnt_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drainCnt_q <= drainCnt_q - CW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.q       = qOut_q;
    assign bus.q_valid = qValid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_skew_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_skew_input_buffer
// Directed self-checking bench for skew_input_buffer with default parameters.
// Expected stream outputs come from a per-edge timestamp formula over a
// reference copy of the memory; the same bench covers both builds
// (INBUF_SKEW_EN defined or not).
// ---------------------------------------------------------------------------
module tb_skew_input_buffer;

    localparam int DW    = 8;
    localparam int LANES = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RW    = LANES * DW;

`ifdef INBUF_SKEW_EN
    localparam int TAIL = LANES;
`else
    localparam int TAIL = 1;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    int             checks = 0;
    int             errors = 0;
    logic [RW-1:0]  refMem [DEPTH];

    skew_input_buffer_if #(.DW(DW), .LANES(LANES), .AW(AW)) bus ();

    skew_input_buffer #(
        .DW(DW), .LANES(LANES), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Row pattern: lane j of row r holds 16*r + j (mod 256).
    function automatic logic [RW-1:0] patRow(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) begin
            v[j*DW +: DW] = DW'(16 * r + j);
        end
        return v;
    endfunction

    // Expected Q after edge e of a stream started at edge 0.
    function automatic logic [RW-1:0] expStreamQ(input int e, input int base, input int len);
        logic [RW-1:0] v;
        int k;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef INBUF_SKEW_EN
            k = e - 1 - i;
`else
            k = e - 1;
`endif
            if (k >= 0 && k < len) begin
                v[i*DW +: DW] = refMem[(base + k) % DEPTH][i*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic logic expStreamValid(input int e, input int len);
        int k;
        logic v;
        v = 1'b0;
        for (int i = 0; i < LANES; i++) begin
`ifdef INBUF_SKEW_EN
            k = e - 1 - i;
`else
            k = e - 1;
`endif
            if (k >= 0 && k < len) v = 1'b1;
        end
        return v;
    endfunction

    function automatic int doneEdge(input int len);
        return (len == 0) ? 1 : len + TAIL;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic retn, input logic cen, input logic wen,
                                 input logic [AW-1:0] a, input logic [RW-1:0] d,
                                 input logic start, input logic [AW-1:0] base,
                                 input logic [AW:0] len);
        bus.retn  = retn;
        bus.cen   = cen;
        bus.wen   = wen;
        bus.a     = a;
        bus.d     = d;
        bus.start = start;
        bus.base  = base;
        bus.len   = len;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic checkOutput(input string tag, input logic [RW-1:0] expQ,
                               input logic expValid, input logic expBusy,
                               input logic expDone);
        checks++;
        assert (bus.q === expQ) else begin
            errors++;
            $error("[TB] FAIL %s q observed=%h expected=%h", tag, bus.q, expQ);
        end
        checks++;
        assert (bus.q_valid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s q_valid observed=%b expected=%b", tag, bus.q_valid, expValid);
        end
        checks++;
        assert (bus.busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, bus.busy, expBusy);
        end
        checks++;
        assert (bus.done === expDone) else begin
            errors++;
            $error("[TB] FAIL %s done observed=%b expected=%b", tag, bus.done, expDone);
        end
    endtask

    task automatic writeRow(input int r, input logic [RW-1:0] v);
        applyStimulus(1'b1, 1'b0, 1'b0, AW'(r), v, 1'b0, '0, '0);
        tick();
        checkOutput($sformatf("write%0d", r), '0, 1'b0, 1'b0, 1'b0);
        refMem[r] = v;
    endtask

    task automatic readRow(input int r, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b1, AW'(r), '0, 1'b0, '0, '0);
        tick();
        checkOutput(tag, refMem[r], 1'b1, 1'b0, 1'b0);
    endtask

    // Runs one stream; optional RETN-low window and illegal accesses while busy.
    task automatic runStream(input int base, input int len, input string tag,
                             input int holdAt, input int holdCycles, input bit busyPoke);
        int dEdge;
        int m;
        bit held;
        dEdge = doneEdge(len);
        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b1, AW'(base), (AW+1)'(len));
        tick();
        checkOutput({tag, " e0"}, '0, 1'b0, 1'b1, 1'b0);
        for (int p = 1; p <= dEdge + holdCycles + 1; p++) begin
            held = (holdCycles > 0) && (p >= holdAt) && (p < holdAt + holdCycles);
            applyIdle();
            bus.retn = !held;
            if (busyPoke && p == 1) begin
                bus.cen = 1'b0;
                bus.wen = 1'b0;
                bus.a   = AW'(5);
                bus.d   = '1;
            end
            if (busyPoke && p == 2) begin
                bus.start = 1'b1;
                bus.base  = AW'(7);
                bus.len   = (AW+1)'(3);
            end
            tick();
            if (held) begin
                checkOutput($sformatf("%s hold p%0d", tag, p),
                            expStreamQ(holdAt - 1, base, len), 1'b0, 1'b1, 1'b0);
            end else begin
                m = (holdCycles > 0 && p >= holdAt + holdCycles) ? p - holdCycles : p;
                checkOutput($sformatf("%s e%0d", tag, m), expStreamQ(m, base, len),
                            expStreamValid(m, len), (m < dEdge), (m == dEdge));
            end
        end
        applyIdle();
    endtask

    // Directed sequence: reset, random access, streams, retention, abort.
    initial begin
        for (int r = 0; r < DEPTH; r++) refMem[r] = '0;
        applyIdle();
        #2;
        checkOutput("reset", '0, 1'b0, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;

        for (int r = 0; r < 4; r++) writeRow(r, patRow(r));
        writeRow(5, patRow(5));
        writeRow(30, patRow(30));
        writeRow(31, patRow(31));

        readRow(2, "read2");
        applyIdle();
        tick();
        checkOutput("read-idle", '0, 1'b0, 1'b0, 1'b0);

        writeRow(4, patRow(4));
        readRow(4, "read-after-write4");
        readRow(31, "read31");

        readRow(3, "read3");
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(3), '0, 1'b0, '0, '0);
        tick();
        checkOutput("retn-idle", '0, 1'b0, 1'b0, 1'b0);
        applyIdle();

        runStream(0, 4, "s0", 0, 0, 1'b0);
        runStream(30, 4, "wrap", 0, 0, 1'b0);
        runStream(0, 0, "len0", 0, 0, 1'b0);
        runStream(0, 4, "retn", 3, 3, 1'b1);
        readRow(5, "busy-write-dropped");

        applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, 1'b1, '0, (AW+1)'(4));
        tick();
        applyIdle();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort-reset", '0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < DEPTH; r++) refMem[r] = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < LANES + 4; c++) begin
            tick();
            checkOutput($sformatf("abort-after c%0d", c), '0, 1'b0, 1'b0, 1'b0);
        end
        readRow(2, "mem-cleared2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skew_input_buffer.md
# skew_input_buffer

Parametrised successor to the team's fixed 16×8-bit, 32-row input buffer. It holds LANES-wide activation rows and serves two kinds of access. Random-access reads and writes go through the same CEN/WEN/A/D/Q port. A new streaming mode reads a run of rows and emits them diagonally skewed, with lane i delayed i cycles, so the skew no longer has to be built at write time. It sits between the activation loader and the west edge of the systolic array.

## Interface
Parameters:
- DW, 8: bits per lane element
- LANES, 16: lanes per row; one per array row
- DEPTH, 32: rows stored
- AW, 5: address width; must equal clog2(DEPTH)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- RETN  in  1  retention enable; low = all accesses ignored and the stream stalled
- CEN  in  1  chip enable, active-low
- WEN  in  1  write enable, active-low
- A  in  AW  random-access row address
- D  in  LANES*DW  write row; lane i = D[i*DW +: DW]
- START  in  1  one-cycle stream request
- BASE  in  AW  first row of the stream
- LEN  in  AW+1  number of rows to stream, 0..DEPTH
- Q  out  LANES*DW  read or stream data; lane i = Q[i*DW +: DW]
- Q_VALID  out  1  Q carries data this cycle
- BUSY  out  1  stream in progress
- DONE  out  1  one-cycle pulse at end of stream

## Operation
- Reset (asynchronous, RESET low):
  - all mem rows, Q, Q_VALID, BUSY and DONE go to 0
  - FSM goes to IDLE
  - skew registers are cleared
  - a stream in flight is aborted, with no DONE pulse
- FSM states: IDLE, STREAM, DRAIN.
- In IDLE with RETN=1, priority order is START, then write, then read:
  - START=1: latch BASE and LEN, set BUSY=1. Go to STREAM, or to DRAIN if LEN=0.
  - ~CEN & ~WEN: mem[A] <= D. Q <= 0, Q_VALID <= 0.
  - ~CEN & WEN: Q <= mem[A] unskewed, Q_VALID <= 1.
  - Otherwise: Q <= 0, Q_VALID <= 0.
- STREAM:
  - row index k counts 0..LEN-1
  - each cycle reads mem[(BASE+k) mod DEPTH]; addresses wrap past DEPTH-1 to 0
  - lane i of the row enters an i-deep delay line; lane 0 has no extra delay
  - after k = LEN-1, go to DRAIN
- DRAIN:
  - zeros are fed into the delay lines for LANES-1 cycles, then go to IDLE
  - when LEN=0, DRAIN lasts 1 cycle and emits nothing
- Stream output:
  - lane i of Q shows row k's lane-i element exactly i cycles after lane 0 of row k
  - lanes with no valid element show 0
  - Q_VALID=1 while any lane carries stream data
- While BUSY=1:
  - CEN/WEN accesses are ignored; writes are dropped
  - START is ignored
- RETN=0:
  - in IDLE: no access occurs; Q and Q_VALID go to 0
  - in STREAM or DRAIN: FSM, counters and delay lines hold; Q holds; Q_VALID=0; DONE is not asserted. Streaming resumes on the cycle RETN returns to 1.
- Memory writes from D are row-aligned; no diagonal placement is done at write time.

## Timing
- Write: mem[A] is visible to a read issued in the next cycle.
- Random read: 1-cycle latency; Q is valid after the edge following the request.
- Stream, with START sampled at edge 0:
  - after edge 1+k+i, lane i of Q = mem[BASE+k] lane i
  - Q_VALID is high for edges 1 .. LEN+LANES-1
- End of stream:
  - DONE=1 for the single cycle after the last valid output (edge LEN+LANES)
  - BUSY falls on the same edge
  - a new START is accepted in the following cycle
- LEN=0: DONE pulses after edge 1; Q_VALID stays 0.

## Configuration
- INBUF_SKEW_EN defined:
  - stream output is skewed as above
  - DRAIN lasts LANES-1 cycles; DONE after edge LEN+LANES
- INBUF_SKEW_EN undefined:
  - delay lines are not built; stream rows appear aligned, all lanes at edge 1+k
  - DRAIN lasts 1 cycle; Q_VALID spans edges 1..LEN; DONE after edge LEN+1
- Random access behaves identically in both builds.

## Test plan
All scenarios use default parameters.

- Write rows 0..3 with lane j = 16·row + j, then read A=2: after 1 cycle Q = row 2, Q_VALID=1; 0 otherwise.
- Skew on: START with BASE=0, LEN=4:
  - lane 0 shows 0x00,0x10,0x20,0x30 at edges 1..4
  - lane 15 shows 0x0F..0x3F at edges 16..19
  - Q_VALID is high for edges 1..19; DONE pulses at edge 20
- Wrap: BASE=30, LEN=4 streams rows 30, 31, 0, 1.
- LEN=0: DONE pulses after edge 1; Q_VALID never rises.
- Mid-stream, three effects are checked:
  - RETN low for 3 cycles extends every timestamp by 3
  - a write issued during BUSY leaves mem unchanged
  - RESET low clears Q, BUSY and mem, and no DONE pulse occurs
- Skew off (INBUF_SKEW_EN undefined), BASE=0, LEN=4: aligned rows at edges 1..4; DONE pulses at edge 5.
